// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - stores a colour sequence and plays it back on one-hot LEDs
// Appends come from the random stage; the answer checker reads entries back through rd_idx.
module sequence_player #(
    parameter int MAX_LEN    = 16,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [1:0]                 rand_in,
    input  logic                       append,
    input  logic                       play,
    input  logic                       clear,
    input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
    output logic [1:0]                 rd_data,
    output logic [3:0]                 led,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MAX_LEN):0]   seq_len,
    output logic                       full
);

    localparam int IW      = $clog2(MAX_LEN);
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    // Timer counts 0 .. MAX_CYC-1 within a phase.
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [IW:0]   LEN_MAX  = (IW + 1)'(MAX_LEN);
    localparam logic [IW:0]   LEN_ONE  = (IW + 1)'(1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]    mem [MAX_LEN];
    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;

    logic          idle;
    logic          start;
    logic          wr_en;
    logic          last_step;
    logic [IW-1:0] next_idx;
    logic [1:0]    first_color;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    assign idle      = (state == S_IDLE);
    assign full      = (seq_len == LEN_MAX);
    // A full append still replays, so only an empty sequence blocks playback.
    assign start     = idle && !clear && (append || (play && (seq_len != '0)));
    assign wr_en     = idle && !clear && append && !full && !reset;
    assign last_step = (({1'b0, idx} + LEN_ONE) == seq_len);
    assign next_idx  = idx + IDX_ONE;
    // When the very first entry is written on the start edge, memory is not yet updated.
    assign first_color = (seq_len == '0) ? rand_in : mem[0];
    assign rd_data   = ({1'b0, rd_idx} < seq_len) ? mem[rd_idx] : 2'b00;

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[seq_len[IW-1:0]] <= rand_in;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            seq_len <= '0;
            idx     <= '0;
            timer   <= '0;
            led     <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        seq_len <= '0;
                    end else if (start) begin
                        if (append && !full) begin
                            seq_len <= seq_len + LEN_ONE;
                        end
                        idx   <= '0;
                        timer <= '0;
                        state <= S_ON;
                        led   <= onehot(first_color);
                        busy  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (timer == ON_LAST) begin
                        state <= S_OFF;
                        timer <= '0;
                        led   <= 4'b0000;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                S_OFF: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (last_step) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= next_idx;
                            state <= S_ON;
                            led   <= onehot(mem[next_idx]);
                        end
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    led   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - self-checking bench for sequence_player
// Reference model: a colour queue plus per-cycle timing derived from step/phase arithmetic.
module tb_sequence_player;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int ML  = 4;
    localparam int PER = ON + OFF;

    logic       clk;
    logic       reset;
    logic [1:0] rand_in;
    logic       append;
    logic       play;
    logic       clear;
    logic [1:0] rd_idx;
    logic [1:0] rd_data;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [2:0] seq_len;
    logic       full;

    int tests = 0;
    int fails = 0;
    int model_q[$];

    sequence_player #(
        .MAX_LEN   (ML),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .rand_in (rand_in),
        .append  (append),
        .play    (play),
        .clear   (clear),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .led     (led),
        .busy    (busy),
        .done    (done),
        .seq_len (seq_len),
        .full    (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int n;
        n = model_q.size();
        check("seq_len", 8'(seq_len), 8'(n));
        check("full", 8'(full), 8'(n == ML));
        for (int i = 0; i < ML; i++) begin
            rd_idx = 2'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), 8'(rd_data), (i < n) ? 8'(model_q[i]) : 8'd0);
        end
    endtask

    // Observations start just after the request edge (k=0); done is due at k = n*PER.
    task automatic run_playback(input int n, input int inject_k);
        int step;
        int ph;
        logic [7:0] e_led;
        logic [7:0] e_busy;
        logic [7:0] e_done;
        for (int k = 0; k <= n * PER; k++) begin
            step = k / PER;
            ph   = k % PER;
            if (k < n * PER) begin
                e_led  = (ph < ON) ? 8'(1 << model_q[step]) : 8'd0;
                e_busy = 8'd1;
                e_done = 8'd0;
            end else begin
                e_led  = 8'd0;
                e_busy = 8'd0;
                e_done = 8'd1;
            end
            check($sformatf("led k=%0d", k), 8'(led), e_led);
            check($sformatf("busy k=%0d", k), 8'(busy), e_busy);
            check($sformatf("done k=%0d", k), 8'(done), e_done);
            if (k < n * PER) begin
                if (k == inject_k) begin
                    append  = 1'b1;
                    rand_in = 2'($urandom_range(0, 3));
                end
                tick();
                append = 1'b0;
            end
        end
        tick();
        check("done_after", 8'(done), 8'd0);
        check("busy_after", 8'(busy), 8'd0);
    endtask

    task automatic request(input bit a, input bit p, input bit c, input logic [1:0] col);
        int n;
        append  = a;
        play    = p;
        clear   = c;
        rand_in = col;
        tick();
        append = 1'b0;
        play   = 1'b0;
        clear  = 1'b0;
        n = 0;
        if (c) begin
            model_q.delete();
        end else if (a) begin
            if (model_q.size() < ML) model_q.push_back(int'(col));
            n = model_q.size();
        end else if (p) begin
            n = model_q.size();
        end
        if (n > 0) begin
            run_playback(n, -1);
        end else begin
            for (int k = 0; k < 3; k++) begin
                check("idle_busy", 8'(busy), 8'd0);
                check("idle_done", 8'(done), 8'd0);
                check("idle_led", 8'(led), 8'd0);
                tick();
            end
        end
        check_status();
    endtask

    initial begin
        int op;
        reset   = 1'b1;
        rand_in = 2'b00;
        append  = 1'b0;
        play    = 1'b0;
        clear   = 1'b0;
        rd_idx  = 2'b00;
        #1;
        check("rst_led", 8'(led), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_seq_len", 8'(seq_len), 8'd0);
        tick();
        tick();
        reset = 1'b0;
        check_status();

        request(1'b1, 1'b0, 1'b0, 2'b10);
        repeat (3) request(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        request(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        request(1'b0, 1'b1, 1'b0, 2'b00);

        // Appends arriving during playback must be dropped, including on the final edge.
        play = 1'b1;
        tick();
        play = 1'b0;
        run_playback(model_q.size(), 3);
        check_status();
        play = 1'b1;
        tick();
        play = 1'b0;
        run_playback(model_q.size(), model_q.size() * PER - 1);
        check_status();

        request(1'b0, 1'b0, 1'b1, 2'b00);
        request(1'b0, 1'b1, 1'b0, 2'b00);
        request(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        request(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
        request(1'b0, 1'b1, 1'b0, 2'b00);

        repeat (10) begin
            op = int'($urandom_range(0, 5));
            if (op <= 3)      request(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
            else if (op == 4) request(1'b0, 1'b1, 1'b0, 2'b00);
            else              request(1'b0, 1'b0, 1'b1, 2'b00);
        end

        // Asynchronous reset while step 2 is lit.
        request(1'b0, 1'b0, 1'b1, 2'b00);
        request(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        request(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
        play = 1'b1;
        tick();
        play = 1'b0;
        repeat (PER + 1) tick();
        check("mid_led", 8'(led), 8'(1 << model_q[1]));
        check("mid_busy", 8'(busy), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_led", 8'(led), 8'd0);
        check("arst_busy", 8'(busy), 8'd0);
        check("arst_done", 8'(done), 8'd0);
        check("arst_seq_len", 8'(seq_len), 8'd0);
        model_q.delete();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2 * PER; k++) begin
            check("post_rst_done", 8'(done), 8'd0);
            check("post_rst_busy", 8'(busy), 8'd0);
            tick();
        end
        check_status();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16; max stored sequence length, power of two.
REQ-002 SHALL have parameter ON_CYCLES, default 25000000; LED-lit time per step in clocks (0.5 s at 50 MHz).
REQ-003 SHALL have parameter OFF_CYCLES, default 12500000; dark gap after each step in clocks.
REQ-004 SHALL have port CLOCK_50, input, 1 bit; the single clock, all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-006 SHALL have port rand_in, input, 2 bits; colour index from the random stage.
REQ-007 SHALL have port append, input, 1 bit; request to add rand_in to the sequence and then play it back.
REQ-008 SHALL have port play, input, 1 bit; request to replay the stored sequence without adding to it.
REQ-009 SHALL have port clear, input, 1 bit; empties the sequence.
REQ-010 SHALL have port rd_idx, input, log2(MAX_LEN) bits; read address for the answer checker.
REQ-011 SHALL have port rd_data, output, 2 bits; combinational read of entry rd_idx.
REQ-012 SHALL have port led, output, 4 bits; one-hot lit colour, where index k lights bit k.
REQ-013 SHALL have port busy, output, 1 bit; high while playback is in progress.
REQ-014 SHALL have port done, output, 1 bit; one-cycle pulse at the end of playback.
REQ-015 SHALL have port seq_len, output, log2(MAX_LEN)+1 bits; number of stored entries.
REQ-016 SHALL have port full, output, 1 bit; high when seq_len == MAX_LEN.

Function
REQ-017 SHALL implement an FSM with states IDLE, ON, OFF; led, busy and done are registered.
REQ-018 SHALL sample requests only in IDLE, with priority clear > append > play; requests while busy SHALL be ignored.
REQ-019 On clear in IDLE: seq_len SHALL become 0; the FSM stays in IDLE; memory contents are don't-care.
REQ-020 On append in IDLE with full=0: mem[seq_len] <= rand_in, seq_len increments, idx <= 0, and the FSM goes to ON, all on the same edge.
REQ-021 On append in IDLE with full=1: there SHALL be no write and seq_len is unchanged; playback SHALL start exactly as for play.
REQ-022 On play in IDLE with seq_len > 0: idx <= 0 and the FSM goes to ON; play with seq_len == 0 SHALL be ignored, with no busy and no done.
REQ-023 In ON: led = onehot(mem[idx]) and busy = 1 for exactly ON_CYCLES clocks, then the FSM goes to OFF.
REQ-024 In OFF: led = 0 and busy = 1 for exactly OFF_CYCLES clocks.
REQ-025 At the end of OFF with idx < seq_len-1: idx increments and the FSM returns to ON; no gap cycle.
REQ-026 At the end of OFF with idx == seq_len-1: the FSM goes to IDLE, busy goes low and done is high for exactly one cycle on that same edge.
REQ-027 Total playback time SHALL be seq_len*(ON_CYCLES+OFF_CYCLES) clocks, from the edge that sampled the request to the edge that raises done.
REQ-028 rd_data SHALL be mem[rd_idx] when rd_idx < seq_len, else 2'b00; it SHALL be valid in all states.
REQ-029 The timer SHALL be sized for max(ON_CYCLES, OFF_CYCLES) and reset to 0 on every state entry.
REQ-030 Stored entries SHALL never be modified except by an append write.

Reset
REQ-031 While reset = 1 (asynchronous): state = IDLE, seq_len = 0, idx = 0, timer = 0, led = 0, busy = 0, done = 0.
REQ-032 Reset mid-playback SHALL abort playback immediately with no done pulse; memory contents are don't-care.

Verification (ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=4)
REQ-033 Reset, then append with rand_in=2'b10 -> led=4'b0100 for 4 clocks, led=0 for 2 clocks, done pulses once at clock 6, seq_len=1, rd_data(idx0)=2'b10.
REQ-034 Three appends with rand_in 01, 11, 00, each issued after done -> third playback shows led 0010, 1000, 0001 (each 4 on / 2 off), done after 18 clocks, seq_len=3.
REQ-035 Fill to 4 entries, then append with rand_in=2'b11 -> full=1, seq_len stays 4, entry 3 unchanged, 24-clock playback of the stored values.
REQ-036 Assert reset during ON of step 2 -> led=0, busy=0, seq_len=0 without waiting for a clock edge; no done.
REQ-037 Append pulsed while busy -> ignored, seq_len unchanged; clear in IDLE -> seq_len=0, full=0; subsequent play -> no busy, no done.
REQ-038 Append and clear in the same IDLE cycle -> clear wins, seq_len=0, no playback.
